uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte push port from the string sequencer plus the drain-side handshake
// to the UART TX controller, bundled with the FIFO status flags.
interface uart_tx_fifo_if #(
   parameter int unsigned AW = 4
) ();
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          busy;
   logic          tx_send;
   logic [7:0]    tx_data;
   logic          tx_ready;

   modport master (
      output wr_en, wr_data, tx_ready,
      input  full, empty, count, overflow, busy, tx_send, tx_data
   );

   modport slave (
      input  wr_en, wr_data, tx_ready,
      output full, empty, count, overflow, busy, tx_send, tx_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART TX controller: pushes from the sequencer are queued
// and a small drain FSM strobes them out one at a time, pacing on tx_ready.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input logic           clk,
   input logic           rst,
   uart_tx_fifo_if.slave bus
);
   localparam int unsigned DW = 8;
   localparam int unsigned CW = AW + 1;

   if (DEPTH != (1 << AW)) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must equal 2**AW");
   end

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          load_c;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          full_q;
   logic          empty_q;
   logic          overflow_q;
   logic          tx_send_q;
   logic [DW-1:0] tx_data_q;
   logic          push_c;
   logic          pop_c;

   // A pop happens on the edge that leaves SEND; pushes are gated only by full.
   always_comb begin
      push_c = bus.wr_en && !full_q;
      pop_c  = (state == SEND);
   end

   // Next-state logic; load_c marks the IDLE->SEND edge that captures tx_data.
   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      case (state)
         IDLE: begin
            if (!empty_q && bus.tx_ready) begin
               state_next = SEND;
               load_c     = 1'b1;
            end
         end
         SEND:      state_next = WAIT_LOW;
         WAIT_LOW:  if (!bus.tx_ready) state_next = WAIT_HIGH;
         WAIT_HIGH: if (bus.tx_ready)  state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      case ({push_c, pop_c})
         2'b10:   count_next = count_q + CW'(1);
         2'b01:   count_next = count_q - CW'(1);
         default: count_next = count_q;
      endcase
   end

   // Drain FSM state and the registered strobe/data toward the controller.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         tx_send_q <= 1'b0;
         tx_data_q <= '0;
      end else begin
         state     <= state_next;
         tx_send_q <= (state_next == SEND);
         if (load_c) tx_data_q <= mem[rd_ptr];
      end
   end

   // Pointers, occupancy and flags; full/empty derive from the next count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_next;
         full_q  <= (count_next == CW'(DEPTH));
         empty_q <= (count_next == '0);
         if (bus.wr_en && full_q) overflow_q <= 1'b1;
      end
   end

   // Storage is not reset; a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= bus.wr_data;
   end

   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.tx_send  = tx_send_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.busy     = !empty_q || (state != IDLE);

   a_empty_consistent: assert property (@(posedge clk) disable iff (rst)
      empty_q == (count_q == '0));
   a_full_consistent: assert property (@(posedge clk) disable iff (rst)
      full_q == (count_q == CW'(DEPTH)));
   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count_q <= CW'(DEPTH));
   a_send_state: assert property (@(posedge clk) disable iff (rst)
      tx_send_q == (state == SEND));
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a scoreboard queue holds pushed bytes and a
// monitor checks every tx_send strobe against it; a controller model drives tx_ready.
module tb_uart_tx_fifo;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   typedef enum int {CTRL_AUTO, CTRL_HOLD, CTRL_LAZY} ctrl_mode_t;

   logic       clk;
   logic       rst;
   ctrl_mode_t ctrl_mode = CTRL_AUTO;
   int         n_tests   = 0;
   int         n_fail    = 0;
   int         n_strobes = 0;
   int         low_left  = 0;
   int         s0;
   logic       mon_prev_ready = 1'b1;
   logic       mon_prev_send  = 1'b0;
   logic [7:0] sb_q [$];

   uart_tx_fifo_if #(.AW(AW)) u_if ();

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Controller model: AUTO goes low for 3 cycles after each strobe, HOLD keeps
   // it busy, LAZY never reports a frame in progress.
   initial begin
      u_if.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ctrl_mode)
            CTRL_HOLD: begin
               u_if.tx_ready = 1'b0;
               low_left      = 0;
            end
            CTRL_LAZY: u_if.tx_ready = 1'b1;
            default: begin
               if (u_if.tx_send === 1'b1) begin
                  u_if.tx_ready = 1'b0;
                  low_left      = 3;
               end else if (low_left > 0) begin
                  low_left--;
                  if (low_left == 0) u_if.tx_ready = 1'b1;
               end else begin
                  u_if.tx_ready = 1'b1;
               end
            end
         endcase
      end
   end

   // Strobe monitor: pops the scoreboard on every tx_send cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (u_if.tx_send === 1'b1) begin
            n_strobes++;
            chk("strobe_ready_before", 32'(mon_prev_ready), 32'd1);
            chk("strobe_single_cycle", 32'(mon_prev_send), 32'd0);
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $error("FAIL unexpected_strobe: observed tx_data 0x%0h expected no strobe", u_if.tx_data);
            end else begin
               chk("tx_data_order", 32'(u_if.tx_data), 32'(sb_q.pop_front()));
            end
         end
         mon_prev_ready = u_if.tx_ready;
         mon_prev_send  = u_if.tx_send;
      end
   end

   task automatic push(input logic [7:0] b, input bit accept);
      @(negedge clk);
      u_if.wr_en   = 1'b1;
      u_if.wr_data = b;
      if (accept) sb_q.push_back(b);
      @(posedge clk);
      #1;
      u_if.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      bit done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         if (u_if.busy === 1'b0) done = 1'b1;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic wait_strobe(input string tag, input int bound);
      bit done = 1'b0;
      for (int i = 0; i < bound && !done; i++) begin
         @(negedge clk);
         if (u_if.tx_send === 1'b1) done = 1'b1;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic hold_ready();
      ctrl_mode = CTRL_HOLD;
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      u_if.wr_en   = 1'b0;
      u_if.wr_data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_empty",    32'(u_if.empty),    32'd1);
      chk("rst_full",     32'(u_if.full),     32'd0);
      chk("rst_count",    32'(u_if.count),    32'd0);
      chk("rst_overflow", 32'(u_if.overflow), 32'd0);
      chk("rst_tx_send",  32'(u_if.tx_send),  32'd0);
      chk("rst_tx_data",  32'(u_if.tx_data),  32'd0);
      chk("rst_busy",     32'(u_if.busy),     32'd0);
      rst = 1'b0;

      // Single byte, checking strobe latency.
      s0 = n_strobes;
      push(8'h48, 1'b1);
      @(negedge clk);
      chk("lat1_count",   32'(u_if.count),   32'd1);
      chk("lat1_nosend",  32'(u_if.tx_send), 32'd0);
      chk("lat1_busy",    32'(u_if.busy),    32'd1);
      @(negedge clk);
      chk("lat1_send",    32'(u_if.tx_send), 32'd1);
      chk("lat1_data",    32'(u_if.tx_data), 32'h48);
      wait_idle("single_idle", 50);
      chk("single_count",   32'(u_if.count),     32'd0);
      chk("single_strobes", 32'(n_strobes - s0), 32'd1);

      // Fill to full, overflow on 17th push, then drain in order.
      hold_ready();
      for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
      @(negedge clk);
      chk("fill_full",     32'(u_if.full),     32'd1);
      chk("fill_count",    32'(u_if.count),    32'd16);
      chk("fill_overflow", 32'(u_if.overflow), 32'd0);
      push(8'hFF, 1'b0);
      @(negedge clk);
      chk("ovf_flag",  32'(u_if.overflow), 32'd1);
      chk("ovf_count", 32'(u_if.count),    32'd16);
      chk("ovf_full",  32'(u_if.full),     32'd1);
      s0 = n_strobes;
      ctrl_mode = CTRL_AUTO;
      wait_idle("fill_idle", 400);
      chk("fill_strobes", 32'(n_strobes - s0), 32'd16);
      chk("fill_empty",   32'(u_if.empty),     32'd1);
      chk("ovf_sticky",   32'(u_if.overflow),  32'd1);

      // Pointer wrap: 10 in/out, then 12 more across the wrap point.
      s0 = n_strobes;
      hold_ready();
      for (int i = 0; i < 10; i++) push(8'h10 + 8'(i), 1'b1);
      ctrl_mode = CTRL_AUTO;
      wait_idle("wrap1_idle", 300);
      chk("wrap1_count", 32'(u_if.count), 32'd0);
      hold_ready();
      for (int i = 0; i < 12; i++) push(8'h40 + 8'(i), 1'b1);
      @(negedge clk);
      chk("wrap2_count", 32'(u_if.count), 32'd12);
      ctrl_mode = CTRL_AUTO;
      wait_idle("wrap2_idle", 300);
      chk("wrap_empty",   32'(u_if.empty),     32'd1);
      chk("wrap_strobes", 32'(n_strobes - s0), 32'd22);

      // Push on the SEND exit edge with 5 queued.
      hold_ready();
      for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b1);
      @(negedge clk);
      chk("c5_count_pre", 32'(u_if.count), 32'd5);
      ctrl_mode = CTRL_AUTO;
      wait_strobe("c5_strobe", 20);
      chk("c5_count_send", 32'(u_if.count), 32'd5);
      u_if.wr_en   = 1'b1;
      u_if.wr_data = 8'hA5;
      sb_q.push_back(8'hA5);
      @(posedge clk);
      #1;
      u_if.wr_en = 1'b0;
      @(negedge clk);
      chk("c5_count_post", 32'(u_if.count),   32'd5);
      chk("c5_send_post",  32'(u_if.tx_send), 32'd0);
      wait_idle("c5_idle", 200);
      chk("c5_drained", 32'(u_if.count), 32'd0);

      // Asynchronous reset while waiting for the controller, 4 bytes queued.
      hold_ready();
      for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1'b1);
      ctrl_mode = CTRL_LAZY;
      wait_strobe("rstm_strobe", 20);
      repeat (2) @(negedge clk);
      chk("rstm_count_pre", 32'(u_if.count),   32'd4);
      chk("rstm_busy_pre",  32'(u_if.busy),    32'd1);
      chk("rstm_send_pre",  32'(u_if.tx_send), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rstm_send",     32'(u_if.tx_send),  32'd0);
      chk("rstm_count",    32'(u_if.count),    32'd0);
      chk("rstm_empty",    32'(u_if.empty),    32'd1);
      chk("rstm_full",     32'(u_if.full),     32'd0);
      chk("rstm_overflow", 32'(u_if.overflow), 32'd0);
      chk("rstm_busy",     32'(u_if.busy),     32'd0);
      chk("rstm_tx_data",  32'(u_if.tx_data),  32'd0);
      sb_q.delete();
      @(negedge clk);
      rst       = 1'b0;
      ctrl_mode = CTRL_AUTO;
      s0        = n_strobes;
      repeat (20) @(negedge clk);
      chk("rstm_no_strobe", 32'(n_strobes - s0), 32'd0);
      chk("rstm_idle",      32'(u_if.busy),      32'd0);
      push(8'h5A, 1'b1);
      @(negedge clk);
      chk("lat2_nosend", 32'(u_if.tx_send), 32'd0);
      chk("lat2_count",  32'(u_if.count),   32'd1);
      @(negedge clk);
      chk("lat2_send",   32'(u_if.tx_send), 32'd1);
      chk("lat2_data",   32'(u_if.tx_data), 32'h5A);
      wait_idle("lat2_idle", 50);

      // Controller busy for 1000 cycles: no strobe, queue intact.
      hold_ready();
      for (int i = 0; i < 3; i++) push(8'h80 + 8'(i), 1'b1);
      s0 = n_strobes;
      repeat (1000) @(negedge clk);
      chk("hold_no_strobe", 32'(n_strobes - s0), 32'd0);
      chk("hold_count",     32'(u_if.count),     32'd3);
      chk("hold_busy",      32'(u_if.busy),      32'd1);
      ctrl_mode = CTRL_AUTO;
      wait_idle("hold_idle", 100);
      chk("hold_strobes", 32'(n_strobes - s0), 32'd3);
      chk("hold_count_end", 32'(u_if.count),   32'd0);
      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
